// File: rtl/i2c_master_bit_engine.sv
// rtl/i2c_master_bit_engine.sv - I2C master bit engine: START/STOP/WRITE/READ bit cycles on an open-drain bus
// Handles clock stretching with a timeout and detects arbitration loss; the controller sees a cmd/rsp handshake.
module i2c_master_bit_engine #(
  parameter int CLK_DIV         = 125,
  parameter int STRETCH_TIMEOUT = 2000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd,
  input  logic       cmd_bit,
  output logic       rsp_valid,
  output logic       rsp_bit,
  output logic [1:0] rsp_err,
  output logic       busy,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl_drive_low,
  output logic       sda_drive_low
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SW = (STRETCH_TIMEOUT > 0) ? $clog2(STRETCH_TIMEOUT + 1) : 1;

  localparam logic [PW-1:0] PH_LAST = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PH_ONE  = PW'(1);
  localparam logic [SW-1:0] ST_LAST = SW'(STRETCH_TIMEOUT - 1);
  localparam logic [SW-1:0] ST_ONE  = SW'(1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PH_A = 3'd1;
  localparam logic [2:0] S_PH_B = 3'd2;
  localparam logic [2:0] S_PH_C = 3'd3;
  localparam logic [2:0] S_PH_D = 3'd4;
  localparam logic [2:0] S_RESP = 3'd5;

  localparam logic [1:0] CMD_START = 2'b00;
  localparam logic [1:0] CMD_STOP  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_STRETCH = 2'b01;
  localparam logic [1:0] ERR_ARB     = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL = 2'b11;

  logic [2:0]    state;
  logic [PW-1:0] ph_cnt;
  logic [SW-1:0] st_cnt;
  logic [1:0]    cmd_r;
  logic          bit_r;
  logic          samp;
  logic          scl_meta, scl_sync;
  logic          sda_meta, sda_sync;

  // Returns {scl_low, sda_low} that a command holds for the whole of a phase.
  function automatic logic [1:0] phase_drive(input logic [2:0] ph, input logic [1:0] c, input logic b);
    logic [1:0] d;
    d = 2'b00;
    case (c)
      CMD_START: begin
        case (ph)
          S_PH_C:  d = 2'b01;
          S_PH_D:  d = 2'b11;
          default: d = 2'b00;
        endcase
      end
      CMD_STOP: begin
        case (ph)
          S_PH_A:  d = 2'b11;
          S_PH_B:  d = 2'b01;
          default: d = 2'b00;
        endcase
      end
      default: begin
        d[1] = (ph == S_PH_A) || (ph == S_PH_D);
        d[0] = (c == CMD_WRITE) && !b;
      end
    endcase
    return d;
  endfunction

  assign cmd_ready = (state == S_IDLE) || (state == S_RESP);
  assign rsp_valid = (state == S_RESP);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      ph_cnt        <= '0;
      st_cnt        <= '0;
      cmd_r         <= CMD_START;
      bit_r         <= 1'b0;
      samp          <= 1'b0;
      scl_meta      <= 1'b1;
      scl_sync      <= 1'b1;
      sda_meta      <= 1'b1;
      sda_sync      <= 1'b1;
      rsp_bit       <= 1'b0;
      rsp_err       <= ERR_OK;
      busy          <= 1'b0;
      scl_drive_low <= 1'b0;
      sda_drive_low <= 1'b0;
    end else begin
      scl_meta <= scl_in;
      scl_sync <= scl_meta;
      sda_meta <= sda_in;
      sda_sync <= sda_meta;

      case (state)
        S_IDLE, S_RESP: begin
          if (cmd_valid) begin
            cmd_r  <= cmd;
            bit_r  <= cmd_bit;
            ph_cnt <= '0;
            st_cnt <= '0;
            if (cmd != CMD_START && !busy) begin
              state   <= S_RESP;
              rsp_err <= ERR_ILLEGAL;
              rsp_bit <= 1'b0;
            end else begin
              state <= S_PH_A;
              {scl_drive_low, sda_drive_low} <= phase_drive(S_PH_A, cmd, cmd_bit);
            end
          end else begin
            state <= S_IDLE;
          end
        end

        S_PH_A: begin
          if (ph_cnt == PH_LAST) begin
            state  <= S_PH_B;
            ph_cnt <= '0;
            st_cnt <= '0;
            {scl_drive_low, sda_drive_low} <= phase_drive(S_PH_B, cmd_r, bit_r);
          end else begin
            ph_cnt <= ph_cnt + PH_ONE;
          end
        end

        // Minimum-length wait that also stretches while a slave holds SCL low.
        S_PH_B: begin
          if (scl_sync) st_cnt <= '0;
          else          st_cnt <= st_cnt + ST_ONE;

          if (!scl_sync && st_cnt == ST_LAST) begin
            state         <= S_RESP;
            rsp_err       <= ERR_STRETCH;
            rsp_bit       <= 1'b0;
            busy          <= 1'b0;
            scl_drive_low <= 1'b0;
            sda_drive_low <= 1'b0;
          end else if (ph_cnt == PH_LAST && scl_sync) begin
            if (cmd_r == CMD_START && !sda_sync) begin
              state         <= S_RESP;
              rsp_err       <= ERR_ARB;
              rsp_bit       <= 1'b0;
              busy          <= 1'b0;
              scl_drive_low <= 1'b0;
              sda_drive_low <= 1'b0;
            end else begin
              state  <= S_PH_C;
              ph_cnt <= '0;
              {scl_drive_low, sda_drive_low} <= phase_drive(S_PH_C, cmd_r, bit_r);
            end
          end else if (ph_cnt != PH_LAST) begin
            ph_cnt <= ph_cnt + PH_ONE;
          end
        end

        S_PH_C: begin
          if (ph_cnt == PH_LAST) begin
            samp <= sda_sync;
            if (cmd_r == CMD_WRITE && bit_r && !sda_sync) begin
              state         <= S_RESP;
              rsp_err       <= ERR_ARB;
              rsp_bit       <= sda_sync;
              busy          <= 1'b0;
              scl_drive_low <= 1'b0;
              sda_drive_low <= 1'b0;
            end else begin
              state  <= S_PH_D;
              ph_cnt <= '0;
              {scl_drive_low, sda_drive_low} <= phase_drive(S_PH_D, cmd_r, bit_r);
            end
          end else begin
            ph_cnt <= ph_cnt + PH_ONE;
          end
        end

        S_PH_D: begin
          if (ph_cnt == PH_LAST) begin
            state   <= S_RESP;
            rsp_err <= ERR_OK;
            rsp_bit <= cmd_r[1] ? samp : 1'b0;
            if (cmd_r == CMD_START)     busy <= 1'b1;
            else if (cmd_r == CMD_STOP) busy <= 1'b0;
          end else begin
            ph_cnt <= ph_cnt + PH_ONE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_bit_engine.sv
// tb/tb_i2c_master_bit_engine.sv - directed scoreboard bench for i2c_master_bit_engine
// Lines are looped back from the drives; a bench slave can hold SCL low or force SDA low.
module tb_i2c_master_bit_engine;

  localparam int CLK_DIV = 4;
  localparam int ST      = 20;

  localparam logic [1:0] C_START = 2'b00;
  localparam logic [1:0] C_STOP  = 2'b01;
  localparam logic [1:0] C_WRITE = 2'b10;
  localparam logic [1:0] C_READ  = 2'b11;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd = 2'b00;
  logic       cmd_bit = 1'b0;
  logic       cmd_ready, rsp_valid, rsp_bit, busy;
  logic [1:0] rsp_err;
  logic       scl_in, sda_in, scl_drive_low, sda_drive_low;

  logic slave_sda_low = 1'b0;
  int   hold_from = -1;
  int   hold_to   = -1;
  int   cyc = 0;

  assign scl_in = !scl_drive_low && !(cyc >= hold_from && cyc < hold_to);
  assign sda_in = !sda_drive_low && !slave_sda_low;

  i2c_master_bit_engine #(.CLK_DIV(CLK_DIV), .STRETCH_TIMEOUT(ST)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd), .cmd_bit(cmd_bit),
    .rsp_valid(rsp_valid), .rsp_bit(rsp_bit), .rsp_err(rsp_err), .busy(busy),
    .scl_in(scl_in), .sda_in(sda_in),
    .scl_drive_low(scl_drive_low), .sda_drive_low(sda_drive_low)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         t_rsp;
    logic       chk_bit;
    logic       bit_v;
    logic [1:0] err;
    logic       busy_v;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;
  int   fails  = 0;
  int   t_acc  = 0;
  int   scl_lo, sda_lo, rsp_cnt;
  logic last_scl, last_sda;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drives one command at a negedge; the scoreboard entry carries the expected response.
  task automatic issue(input string tag, input logic [1:0] c, input logic b, input int lat,
                       input logic chk_b, input logic eb, input logic [1:0] ee, input logic ebusy,
                       input int h_lo, input int h_hi);
    exp_t e;
    @(negedge clk);
    check({tag, "_ready_before"}, cmd_ready, 1);
    cmd       = c;
    cmd_bit   = b;
    cmd_valid = 1'b1;
    t_acc     = cyc;
    if (h_lo >= 0) begin
      hold_from = cyc + h_lo;
      hold_to   = cyc + h_hi;
    end else begin
      hold_from = -1;
      hold_to   = -1;
    end
    e.t_rsp   = cyc + lat;
    e.chk_bit = chk_b;
    e.bit_v   = eb;
    e.err     = ee;
    e.busy_v  = ebusy;
    sb.push_back(e);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_bit   = 1'b0;
    check({tag, "_ready_after"}, cmd_ready, (lat == 1) ? 1 : 0);
  endtask

  task automatic wait_rsp(input string tag, input int budget);
    exp_t e;
    logic got;
    got    = 1'b0;
    scl_lo = 0;
    sda_lo = 0;
    for (int n = 0; n < budget && !got; n++) begin
      @(negedge clk);
      if (rsp_valid) got = 1'b1;
      else begin
        if (scl_drive_low) scl_lo++;
        if (sda_drive_low) sda_lo++;
        last_scl = scl_drive_low;
        last_sda = sda_drive_low;
      end
    end
    if (!got) begin
      check({tag, "_rsp_seen"}, 0, 1);
      if (sb.size() > 0) void'(sb.pop_front());
    end else if (sb.size() == 0) begin
      check({tag, "_sb_nonempty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      check({tag, "_rsp_cycle"}, cyc, e.t_rsp);
      check({tag, "_rsp_err"}, rsp_err, e.err);
      check({tag, "_busy"}, busy, e.busy_v);
      check({tag, "_resp_ready"}, cmd_ready, 1);
      if (e.chk_bit) check({tag, "_rsp_bit"}, rsp_bit, e.bit_v);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_bit", rsp_bit, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_busy", busy, 0);
    check("rst_scl_drive", scl_drive_low, 0);
    check("rst_sda_drive", sda_drive_low, 0);
    @(negedge clk);
    reset_n = 1'b1;

    issue("stop_idle", C_STOP, 1'b0, 1, 1'b0, 1'b0, 2'b11, 1'b0, -1, -1);
    wait_rsp("stop_idle", 5);
    check("stop_idle_scl", scl_drive_low, 0);
    check("stop_idle_sda", sda_drive_low, 0);

    issue("start", C_START, 1'b0, 4*CLK_DIV+1, 1'b0, 1'b0, 2'b00, 1'b1, -1, -1);
    wait_rsp("start", 40);
    check("start_end_scl", scl_drive_low, 1);
    check("start_end_sda", sda_drive_low, 1);

    issue("write0", C_WRITE, 1'b0, 4*CLK_DIV+1, 1'b1, 1'b0, 2'b00, 1'b1, -1, -1);
    wait_rsp("write0", 40);
    check("write0_sda_low_cycles", sda_lo, 16);
    check("write0_scl_low_cycles", scl_lo, 8);

    issue("read", C_READ, 1'b0, 4*CLK_DIV+1, 1'b1, 1'b1, 2'b00, 1'b1, -1, -1);
    wait_rsp("read", 40);
    check("read_sda_low_cycles", sda_lo, 0);
    check("read_scl_low_cycles", scl_lo, 8);

    // Slave holds SCL for PH_B cycles 0-11, so PH_B lasts 15 cycles.
    issue("stretch", C_WRITE, 1'b1, 28, 1'b1, 1'b1, 2'b00, 1'b1, CLK_DIV+1, CLK_DIV+13);
    wait_rsp("stretch", 60);

    slave_sda_low = 1'b1;
    issue("arb", C_WRITE, 1'b1, 3*CLK_DIV+1, 1'b1, 1'b0, 2'b10, 1'b0, -1, -1);
    wait_rsp("arb", 40);
    check("arb_lastc_scl", last_scl, 0);
    check("arb_lastc_sda", last_sda, 0);
    check("arb_resp_scl", scl_drive_low, 0);
    check("arb_resp_sda", sda_drive_low, 0);
    slave_sda_low = 1'b0;

    issue("start2", C_START, 1'b0, 4*CLK_DIV+1, 1'b0, 1'b0, 2'b00, 1'b1, -1, -1);
    wait_rsp("start2", 40);

    issue("timeout", C_WRITE, 1'b0, CLK_DIV+1+ST, 1'b0, 1'b0, 2'b01, 1'b0, CLK_DIV+1, 1 << 30);
    wait_rsp("timeout", 60);
    check("timeout_scl", scl_drive_low, 0);
    check("timeout_sda", sda_drive_low, 0);

    issue("start3", C_START, 1'b0, 4*CLK_DIV+1, 1'b0, 1'b0, 2'b00, 1'b1, -1, -1);
    wait_rsp("start3", 40);

    issue("stop", C_STOP, 1'b0, 4*CLK_DIV+1, 1'b0, 1'b0, 2'b00, 1'b0, -1, -1);
    wait_rsp("stop", 40);
    check("stop_end_scl", scl_drive_low, 0);
    check("stop_end_sda", sda_drive_low, 0);

    issue("start4", C_START, 1'b0, 4*CLK_DIV+1, 1'b0, 1'b0, 2'b00, 1'b1, -1, -1);
    wait_rsp("start4", 40);

    // Reset in the middle of PH_C of a WRITE 0: response must never come.
    issue("rst_mid", C_WRITE, 1'b0, 4*CLK_DIV+1, 1'b0, 1'b0, 2'b00, 1'b1, -1, -1);
    for (int n = 0; n < 40 && cyc < t_acc + 2*CLK_DIV + 2; n++) @(negedge clk);
    check("rst_mid_pre_sda", sda_drive_low, 1);
    check("rst_mid_pre_scl", scl_drive_low, 0);
    reset_n = 1'b0;
    #1;
    check("rst_mid_sda", sda_drive_low, 0);
    check("rst_mid_scl", scl_drive_low, 0);
    check("rst_mid_ready", cmd_ready, 1);
    check("rst_mid_busy", busy, 0);
    if (sb.size() > 0) void'(sb.pop_front());
    rsp_cnt = 0;
    repeat (2) begin
      @(negedge clk);
      if (rsp_valid) rsp_cnt++;
    end
    reset_n = 1'b1;
    repeat (24) begin
      @(negedge clk);
      if (rsp_valid) rsp_cnt++;
    end
    check("rst_mid_no_rsp", rsp_cnt, 0);

    issue("write_after_rst", C_WRITE, 1'b1, 1, 1'b0, 1'b0, 2'b11, 1'b0, -1, -1);
    wait_rsp("write_after_rst", 5);
    check("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
